pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline hazard inputs and control/status outputs for pipe_ctrl.
// The master side drives pipeline state; the slave side (pipe_ctrl) returns control.
interface pipe_ctrl_if;
  logic [63:0] f_predPC;
  logic [3:0]  D_icode;
  logic [3:0]  E_icode;
  logic [3:0]  M_icode;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  E_dstM;
  logic        e_Cnd;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;

  logic [63:0] F_predPC;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        M_bubble;
  logic        W_stall;
  logic        set_cc;
  logic        halted;
  logic [2:0]  halt_stat;
  logic [31:0] cycle_cnt;
  logic [15:0] lu_cnt;
  logic [15:0] mp_cnt;
  logic [15:0] ret_cnt;

  modport master (
    output f_predPC, D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, m_stat, W_stat,
    input  F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, halt_stat, cycle_cnt, lu_cnt, mp_cnt, ret_cnt
  );

  modport slave (
    input  f_predPC, D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, m_stat, W_stat,
    output F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, halted, halt_stat, cycle_cnt, lu_cnt, mp_cnt, ret_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: stall/bubble generation, halt on writeback exception,
// fetch PC register and saturating event counters.
module pipe_ctrl (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPOPQ   = 4'd11;
  localparam logic [3:0] RNONE   = 4'd15;
  localparam logic [2:0] S_ADR   = 3'd2;
  localparam logic [2:0] S_INS   = 3'd3;
  localparam logic [2:0] S_HLT   = 3'd4;
  localparam logic [2:0] S_AOK   = 3'd1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic        load_use, mispredict, ret_hz, m_exc, w_exc;
  logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;
  logic [63:0] pc_q;
  logic [2:0]  halt_stat_q;
  logic [31:0] cycle_q;
  logic [15:0] lu_q, mp_q, ret_q;

  always_comb begin
    load_use   = (bus.E_icode == IMRMOVQ || bus.E_icode == IPOPQ) &&
                 (bus.E_dstM != RNONE) &&
                 (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    mispredict = (bus.E_icode == IJXX) && !bus.e_Cnd;
    ret_hz     = (bus.D_icode == IRET) || (bus.E_icode == IRET) || (bus.M_icode == IRET);
    m_exc      = bus.m_stat inside {S_ADR, S_INS, S_HLT};
    w_exc      = bus.W_stat inside {S_ADR, S_INS, S_HLT};
  end

  // Load-use wins over ret for the decode register: stalling keeps the
  // dependent instruction, so it must not also be bubbled.
  always_comb begin
    state_d  = state_q;
    f_stall  = load_use || ret_hz;
    d_stall  = load_use;
    d_bubble = mispredict || (ret_hz && !load_use);
    e_bubble = mispredict || load_use;
    m_bubble = m_exc || w_exc;
    w_stall  = w_exc;
    set_cc   = (bus.E_icode == IOPQ) && !m_exc && !w_exc;
    case (state_q)
      RUN: begin
        if (w_exc) state_d = HALTED;
      end
      HALTED: begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        w_stall  = 1'b1;
        m_bubble = 1'b1;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        set_cc   = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Everything here is frozen once halted; only reset brings it back.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      halt_stat_q <= S_AOK;
      cycle_q     <= '0;
      lu_q        <= '0;
      mp_q        <= '0;
      ret_q       <= '0;
    end else if (state_q == RUN) begin
      if (cycle_q != '1)             cycle_q <= cycle_q + 32'd1;
      if (load_use   && lu_q  != '1) lu_q    <= lu_q + 16'd1;
      if (mispredict && mp_q  != '1) mp_q    <= mp_q + 16'd1;
      if (ret_hz     && ret_q != '1) ret_q   <= ret_q + 16'd1;
      if (!f_stall)                  pc_q    <= bus.f_predPC;
      if (w_exc)                     halt_stat_q <= bus.W_stat;
    end
  end

  assign bus.F_stall   = f_stall;
  assign bus.D_stall   = d_stall;
  assign bus.D_bubble  = d_bubble;
  assign bus.E_bubble  = e_bubble;
  assign bus.M_bubble  = m_bubble;
  assign bus.W_stall   = w_stall;
  assign bus.set_cc    = set_cc;
  assign bus.F_predPC  = pc_q;
  assign bus.halted    = (state_q == HALTED);
  assign bus.halt_stat = halt_stat_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.lu_cnt    = lu_q;
  assign bus.mp_cnt    = mp_q;
  assign bus.ret_cnt   = ret_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios, random stimulus
// against a behavioural model, and load-use counter saturation.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_init   = 1'b0;
  bit          m_halted = 1'b0;
  logic [2:0]  m_hstat  = 3'd1;
  logic [63:0] m_pc     = '0;
  longint      m_cycle  = 0;
  int          m_lu     = 0;
  int          m_mp     = 0;
  int          m_ret    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check combinational control before the edge,
  // advance the model at the edge, then check registered state.
  task automatic applyStimulus(input bit rst, input logic [3:0] dic, input logic [3:0] eic,
                               input logic [3:0] mic, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] edm, input bit cnd, input logic [2:0] mst,
                               input logic [2:0] wst, input logic [63:0] pc);
    bit lu, mp, rt, mexc, wexc, fs;
    logic [6:0] exp_ctrl;
    reset        = rst;
    bus.D_icode  = dic;
    bus.E_icode  = eic;
    bus.M_icode  = mic;
    bus.d_srcA   = sa;
    bus.d_srcB   = sb;
    bus.E_dstM   = edm;
    bus.e_Cnd    = cnd;
    bus.m_stat   = mst;
    bus.W_stat   = wst;
    bus.f_predPC = pc;
    #1;
    lu   = (eic == 4'd5 || eic == 4'd11) && edm != 4'd15 && (edm == sa || edm == sb);
    mp   = (eic == 4'd7) && !cnd;
    rt   = (dic == 4'd9) || (eic == 4'd9) || (mic == 4'd9);
    mexc = (mst >= 3'd2 && mst <= 3'd4);
    wexc = (wst >= 3'd2 && wst <= 3'd4);
    fs   = m_halted ? 1'b1 : (lu || rt);
    if (m_halted)
      exp_ctrl = 7'b1100110;
    else
      exp_ctrl = {lu || rt, lu, mp || (rt && !lu), mp || lu, mexc || wexc, wexc,
                  (eic == 4'd6) && !mexc && !wexc};
    if (m_init)
      checkOutput("ctrl{F_st,D_st,D_bub,E_bub,M_bub,W_st,cc}",
                  {57'd0, bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                   bus.M_bubble, bus.W_stall, bus.set_cc}, {57'd0, exp_ctrl});
    @(posedge clk);
    if (rst) begin
      m_init   = 1'b1;
      m_halted = 1'b0;
      m_hstat  = 3'd1;
      m_pc     = '0;
      m_cycle  = 0;
      m_lu     = 0;
      m_mp     = 0;
      m_ret    = 0;
    end else if (!m_halted) begin
      if (m_cycle < 64'hFFFF_FFFF) m_cycle++;
      if (lu && m_lu  < 65535) m_lu++;
      if (mp && m_mp  < 65535) m_mp++;
      if (rt && m_ret < 65535) m_ret++;
      if (!fs) m_pc = pc;
      if (wexc) begin
        m_halted = 1'b1;
        m_hstat  = wst;
      end
    end
    #1;
    if (m_init) begin
      checkOutput("F_predPC",  bus.F_predPC,  m_pc);
      checkOutput("halted",    {63'd0, bus.halted}, {63'd0, m_halted});
      checkOutput("halt_stat", {61'd0, bus.halt_stat}, {61'd0, m_hstat});
      checkOutput("cycle_cnt", {32'd0, bus.cycle_cnt}, m_cycle);
      checkOutput("lu_cnt",    {48'd0, bus.lu_cnt},  64'(m_lu));
      checkOutput("mp_cnt",    {48'd0, bus.mp_cnt},  64'(m_mp));
      checkOutput("ret_cnt",   {48'd0, bus.ret_cnt}, 64'(m_ret));
    end
  endtask

  task automatic idle(input bit rst, input logic [63:0] pc);
    applyStimulus(rst, 4'd1, 4'd1, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, pc);
  endtask

  function automatic logic [3:0] rand_icode();
    logic [3:0] tbl [6] = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic logic [3:0] rand_reg();
    if ($urandom_range(0, 3) == 0) return 4'd15;
    return 4'($urandom_range(0, 4));
  endfunction

  function automatic logic [2:0] rand_stat(input int exc_odds);
    if ($urandom_range(0, exc_odds - 1) == 0) return 3'($urandom_range(2, 4));
    return 3'd1;
  endfunction

  initial begin
    // Reset and quiet fetch
    idle(1'b1, 64'h0);
    checkOutput("rst_halted", {63'd0, bus.halted}, 64'd0);
    checkOutput("rst_halt_stat", {61'd0, bus.halt_stat}, 64'd1);
    checkOutput("rst_cycle", {32'd0, bus.cycle_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b0, 64'h0A);
    checkOutput("pc_0a", bus.F_predPC, 64'h0A);
    checkOutput("cycle_3", {32'd0, bus.cycle_cnt}, 64'd3);

    // Load-use, then the same with RNONE destination
    applyStimulus(1'b0, 4'd1, 4'd5, 4'd1, 4'd3, 4'd15, 4'd3, 1'b1, 3'd1, 3'd1, 64'h20);
    checkOutput("lu_pc_hold", bus.F_predPC, 64'h0A);
    checkOutput("lu_cnt_1", {48'd0, bus.lu_cnt}, 64'd1);
    applyStimulus(1'b0, 4'd1, 4'd5, 4'd1, 4'd3, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, 64'h20);
    checkOutput("rnone_no_stall", {63'd0, bus.F_stall}, 64'd0);

    // Mispredict, then taken branch
    applyStimulus(1'b0, 4'd1, 4'd7, 4'd1, 4'd15, 4'd15, 4'd15, 1'b0, 3'd1, 3'd1, 64'h30);
    checkOutput("mp_cnt_1", {48'd0, bus.mp_cnt}, 64'd1);
    applyStimulus(1'b0, 4'd1, 4'd7, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, 64'h38);

    // Ret walking down the pipe, then ret together with load-use
    applyStimulus(1'b0, 4'd9, 4'd1, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, 64'h40);
    applyStimulus(1'b0, 4'd1, 4'd9, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, 64'h40);
    applyStimulus(1'b0, 4'd1, 4'd1, 4'd9, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd1, 64'h40);
    checkOutput("ret_cnt_3", {48'd0, bus.ret_cnt}, 64'd3);
    applyStimulus(1'b0, 4'd9, 4'd11, 4'd1, 4'd15, 4'd2, 4'd2, 1'b1, 3'd1, 3'd1, 64'h48);
    checkOutput("lu_ret_dbub", {63'd0, bus.D_bubble}, 64'd0);
    checkOutput("lu_ret_dstall", {63'd0, bus.D_stall}, 64'd1);

    // Memory exception, writeback exception halts, then frozen, then reset
    applyStimulus(1'b0, 4'd1, 4'd6, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd3, 3'd1, 64'h50);
    checkOutput("mexc_setcc", {63'd0, bus.set_cc}, 64'd0);
    checkOutput("mexc_mbub", {63'd0, bus.M_bubble}, 64'd1);
    applyStimulus(1'b0, 4'd1, 4'd6, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 3'd1, 3'd3, 64'h58);
    checkOutput("halt_flag", {63'd0, bus.halted}, 64'd1);
    checkOutput("halt_stat_3", {61'd0, bus.halt_stat}, 64'd3);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, rand_icode(), rand_icode(), rand_icode(), rand_reg(), rand_reg(),
                    rand_reg(), 1'($urandom_range(0, 1)), rand_stat(2), rand_stat(2),
                    {$urandom, $urandom});
    idle(1'b1, 64'h60);
    checkOutput("post_rst_halted", {63'd0, bus.halted}, 64'd0);
    checkOutput("post_rst_lu", {48'd0, bus.lu_cnt}, 64'd0);

    // Random traffic with occasional exceptions and resets
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, m_halted ? 5 : 150) == 0), rand_icode(), rand_icode(),
                    rand_icode(), rand_reg(), rand_reg(), rand_reg(),
                    1'($urandom_range(0, 1)), rand_stat(16), rand_stat(40),
                    {$urandom, $urandom});

    // Saturate the load-use counter
    idle(1'b1, 64'h0);
    for (int i = 0; i < 65540; i++)
      applyStimulus(1'b0, 4'd1, 4'd5, 4'd1, 4'd3, 4'd15, 4'd3, 1'b1, 3'd1, 3'd1, 64'h70);
    checkOutput("lu_sat", {48'd0, bus.lu_cnt}, 64'hFFFF);
    checkOutput("cycle_after_sat", {32'd0, bus.cycle_cnt}, 64'd65540);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
